// File: rtl/reg_wb_ctrl.sv
// reg_wb_ctrl
//   Write-side controller for the register file. Merges ALU results and buffered
//   memory-load results onto the file's single write port (dyt_sel/D/load_en) and
//   keeps a busy scoreboard of registers whose loads are still in flight.
//
// Ports
//   clk, rst_n                    clock (rising edge), asynchronous active-low reset
//   alu_valid/alu_dst/alu_data    ALU result, highest priority, never back-pressured
//   mem_issue/mem_issue_dst       load issued: mark destination busy
//   mem_valid/mem_ready           load result handshake into the result FIFO
//   mem_dst/mem_data              load result payload
//   A_sel/B_sel, a_busy/b_busy    hazard probes on the file's read selects
//   stall                         FIFO full, upstream must hold ALU issue
//   dyt_sel/D/load_en             registered register-file write port
module reg_wb_ctrl #(
  parameter int DW     = 16,
  parameter int AW     = 4,
  parameter int FDEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_dst,
  input  logic [DW-1:0] alu_data,
  input  logic          mem_issue,
  input  logic [AW-1:0] mem_issue_dst,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_dst,
  input  logic [DW-1:0] mem_data,
  input  logic [AW-1:0] A_sel,
  input  logic [AW-1:0] B_sel,
  output logic          a_busy,
  output logic          b_busy,
  output logic          stall,
  output logic [AW-1:0] dyt_sel,
  output logic [DW-1:0] D,
  output logic          load_en
);

  localparam int IW   = $clog2(FDEPTH);
  localparam int PW   = IW + 1;
  localparam int NREG = 1 << AW;

  logic [AW-1:0]   fifo_dst  [FDEPTH];
  logic [DW-1:0]   fifo_data [FDEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr, count;
  logic [IW-1:0]   wr_idx, rd_idx;
  logic            full, empty, push, pop;
  logic [NREG-1:0] busy, busy_nxt;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign count  = wr_ptr - rd_ptr;
  assign full   = (count == PW'(FDEPTH));
  assign empty  = (count == '0);
  assign wr_idx = wr_ptr[IW-1:0];
  assign rd_idx = rd_ptr[IW-1:0];

  // The head leaves whenever the ALU is idle, so a full FIFO can still take a
  // result in that cycle: the pop frees the slot the push lands in.
  assign pop       = !alu_valid && !empty;
  assign mem_ready = !full || pop;
  assign push      = mem_valid && mem_ready;
  assign stall     = full;

  assign a_busy = busy[A_sel];
  assign b_busy = busy[B_sel];

  // Payload storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dst[wr_idx]  <= mem_dst;
      fifo_data[wr_idx] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Clear applied before set so a same-cycle reissue keeps the register busy.
  always_comb begin
    busy_nxt = busy;
    if (pop)       busy_nxt[fifo_dst[rd_idx]] = 1'b0;
    if (mem_issue) busy_nxt[mem_issue_dst]    = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_en <= 1'b0;
      dyt_sel <= '0;
      D       <= '0;
    end else if (alu_valid) begin
      load_en <= 1'b1;
      dyt_sel <= alu_dst;
      D       <= alu_data;
    end else if (pop) begin
      load_en <= 1'b1;
      dyt_sel <= fifo_dst[rd_idx];
      D       <= fifo_data[rd_idx];
    end else begin
      load_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_wb_ctrl.sv
module tb_reg_wb_ctrl;

  localparam int DW     = 16;
  localparam int AW     = 4;
  localparam int FDEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid;
  logic [AW-1:0] alu_dst;
  logic [DW-1:0] alu_data;
  logic          mem_issue;
  logic [AW-1:0] mem_issue_dst;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_dst;
  logic [DW-1:0] mem_data;
  logic [AW-1:0] A_sel, B_sel;
  logic          a_busy, b_busy, stall;
  logic [AW-1:0] dyt_sel;
  logic [DW-1:0] D;
  logic          load_en;

  reg_wb_ctrl #(.DW(DW), .AW(AW), .FDEPTH(FDEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data),
    .mem_issue(mem_issue), .mem_issue_dst(mem_issue_dst),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dst(mem_dst), .mem_data(mem_data),
    .A_sel(A_sel), .B_sel(B_sel), .a_busy(a_busy), .b_busy(b_busy), .stall(stall),
    .dyt_sel(dyt_sel), .D(D), .load_en(load_en)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic          av;
    logic [AW-1:0] ad;
    logic [DW-1:0] adata;
    logic          mi;
    logic [AW-1:0] mid;
    logic          mv;
    logic [AW-1:0] md;
    logic [DW-1:0] mdata;
    logic          e_ready, e_stall, e_ab, e_bb, e_le;
    logic [AW-1:0] e_dyt;
    logic [DW-1:0] e_d;
  } vec_t;

  function automatic vec_t mk(int av, int ad, int adata, int mi, int mid, int mv, int md,
                              int mdata, int rdy, int stl, int ab, int bb, int le,
                              int dyt, int d);
    vec_t v;
    v.av = av[0]; v.ad = ad[AW-1:0]; v.adata = adata[DW-1:0];
    v.mi = mi[0]; v.mid = mid[AW-1:0];
    v.mv = mv[0]; v.md = md[AW-1:0]; v.mdata = mdata[DW-1:0];
    v.e_ready = rdy[0]; v.e_stall = stl[0]; v.e_ab = ab[0]; v.e_bb = bb[0];
    v.e_le = le[0]; v.e_dyt = dyt[AW-1:0]; v.e_d = d[DW-1:0];
    return v;
  endfunction

  typedef struct {
    logic [AW-1:0] dst;
    logic [DW-1:0] data;
  } ent_t;

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_dst = '0; alu_data = '0;
    mem_issue = 1'b0; mem_issue_dst = '0;
    mem_valid = 1'b0; mem_dst = '0; mem_data = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_load_en"}, 32'(load_en), 32'd0);
    chk({tag, "_dyt_sel"}, 32'(dyt_sel), 32'd0);
    chk({tag, "_D"}, 32'(D), 32'd0);
    chk({tag, "_mem_ready"}, 32'(mem_ready), 32'd1);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_a_busy"}, 32'(a_busy), 32'd0);
    chk({tag, "_b_busy"}, 32'(b_busy), 32'd0);
  endtask

  vec_t tbl[16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed vectors, A_sel=5 and B_sel=7 throughout.
    //            av ad adata    mi mid mv md mdata   rdy stl ab bb le dyt d
    tbl[0]  = mk(1, 3, 'hBEEF, 0, 0, 0, 0, 0,      1, 0, 0, 0, 1, 3, 'hBEEF);
    tbl[1]  = mk(0, 0, 0,      1, 5, 0, 0, 0,      1, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,      0, 0, 1, 5, 'h1234, 1, 0, 1, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0,      0, 0, 0, 0, 0,      1, 0, 1, 0, 1, 5, 'h1234);
    tbl[4]  = mk(0, 0, 0,      0, 0, 0, 0, 0,      1, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 1, 'h1111, 0, 0, 1, 8, 'hAAAA, 1, 0, 0, 0, 1, 1, 'h1111);
    tbl[6]  = mk(1, 2, 'h2222, 0, 0, 1, 9, 'hBBBB, 1, 0, 0, 0, 1, 2, 'h2222);
    tbl[7]  = mk(1, 3, 'h3333, 0, 0, 1,10, 'hCCCC, 0, 1, 0, 0, 1, 3, 'h3333);
    tbl[8]  = mk(0, 0, 0,      0, 0, 1,10, 'hCCCC, 1, 1, 0, 0, 1, 8, 'hAAAA);
    tbl[9]  = mk(0, 0, 0,      0, 0, 0, 0, 0,      1, 1, 0, 0, 1, 9, 'hBBBB);
    tbl[10] = mk(0, 0, 0,      0, 0, 0, 0, 0,      1, 0, 0, 0, 1,10, 'hCCCC);
    tbl[11] = mk(0, 0, 0,      0, 0, 0, 0, 0,      1, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0,      1, 7, 0, 0, 0,      1, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 0, 0,      0, 0, 1, 7, 'h7777, 1, 0, 0, 1, 0, 0, 0);
    tbl[14] = mk(0, 0, 0,      1, 7, 0, 0, 0,      1, 0, 0, 1, 1, 7, 'h7777);
    tbl[15] = mk(0, 0, 0,      0, 0, 0, 0, 0,      1, 0, 0, 1, 0, 0, 0);

    idle_inputs();
    A_sel = 4'd5; B_sel = 4'd7;
    rst_n = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      alu_valid = tbl[i].av; alu_dst = tbl[i].ad; alu_data = tbl[i].adata;
      mem_issue = tbl[i].mi; mem_issue_dst = tbl[i].mid;
      mem_valid = tbl[i].mv; mem_dst = tbl[i].md; mem_data = tbl[i].mdata;
      @(negedge clk);
      chk($sformatf("v%0d_mem_ready", i), 32'(mem_ready), 32'(tbl[i].e_ready));
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
      chk($sformatf("v%0d_a_busy", i), 32'(a_busy), 32'(tbl[i].e_ab));
      chk($sformatf("v%0d_b_busy", i), 32'(b_busy), 32'(tbl[i].e_bb));
      @(posedge clk); #1;
      chk($sformatf("v%0d_load_en", i), 32'(load_en), 32'(tbl[i].e_le));
      if (tbl[i].e_le) begin
        chk($sformatf("v%0d_dyt_sel", i), 32'(dyt_sel), 32'(tbl[i].e_dyt));
        chk($sformatf("v%0d_D", i), 32'(D), 32'(tbl[i].e_d));
      end
    end
    idle_inputs();

    // Reset while two results are buffered and busy bits are pending.
    A_sel = 4'd4; B_sel = 4'd6;
    for (int i = 0; i < 2; i++) begin
      alu_valid = 1'b1; alu_dst = 4'd1; alu_data = 16'(i);
      mem_issue = 1'b1; mem_issue_dst = (i == 0) ? 4'd4 : 4'd6;
      mem_valid = 1'b1; mem_dst = (i == 0) ? 4'd4 : 4'd6; mem_data = 16'h5A00 + 16'(i);
      @(posedge clk); #1;
    end
    idle_inputs();
    alu_valid = 1'b1;
    @(negedge clk);
    chk("pre_rst_stall", 32'(stall), 32'd1);
    chk("pre_rst_a_busy", 32'(a_busy), 32'd1);
    chk("pre_rst_b_busy", 32'(b_busy), 32'd1);
    #2;
    alu_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_load_en%0d", i), 32'(load_en), 32'd0);
      chk($sformatf("post_rst_mem_ready%0d", i), 32'(mem_ready), 32'd1);
    end

    // Randomized traffic against a queue/array reference model.
    begin
      ent_t          q[$];
      logic          mbusy[1 << AW];
      logic          hold;
      logic          exp_ready, acc, exp_le;
      logic [AW-1:0] exp_dyt;
      logic [DW-1:0] exp_d;
      ent_t          h, e;
      foreach (mbusy[k]) mbusy[k] = 1'b0;
      hold = 1'b0;
      for (int n = 0; n < 400; n++) begin
        alu_valid = ($urandom_range(0, 9) < 4);
        alu_dst = AW'($urandom); alu_data = DW'($urandom);
        mem_issue = ($urandom_range(0, 9) < 3);
        mem_issue_dst = AW'($urandom);
        if (!hold) begin
          mem_valid = ($urandom_range(0, 1) == 1);
          mem_dst = AW'($urandom); mem_data = DW'($urandom);
        end
        A_sel = AW'($urandom); B_sel = AW'($urandom);
        @(negedge clk);
        exp_ready = (q.size() < FDEPTH) || (!alu_valid && q.size() > 0);
        chk("rnd_mem_ready", 32'(mem_ready), 32'(exp_ready));
        chk("rnd_stall", 32'(stall), 32'(q.size() == FDEPTH));
        chk("rnd_a_busy", 32'(a_busy), 32'(mbusy[A_sel]));
        chk("rnd_b_busy", 32'(b_busy), 32'(mbusy[B_sel]));
        acc = mem_valid && exp_ready;
        exp_le = 1'b0; exp_dyt = '0; exp_d = '0;
        if (alu_valid) begin
          exp_le = 1'b1; exp_dyt = alu_dst; exp_d = alu_data;
        end else if (q.size() > 0) begin
          h = q.pop_front();
          mbusy[h.dst] = 1'b0;
          exp_le = 1'b1; exp_dyt = h.dst; exp_d = h.data;
        end
        if (acc) begin
          e.dst = mem_dst; e.data = mem_data;
          q.push_back(e);
        end
        if (mem_issue) mbusy[mem_issue_dst] = 1'b1;
        @(posedge clk); #1;
        chk("rnd_load_en", 32'(load_en), 32'(exp_le));
        if (exp_le) begin
          chk("rnd_dyt_sel", 32'(dyt_sel), 32'(exp_dyt));
          chk("rnd_D", 32'(D), 32'(exp_d));
        end
        hold = mem_valid && !acc;
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
